// File: rtl/elastic_multiplier_pkg.sv
// Shared constants, mode enum and the mode-dependent extend-and-multiply helper.
package multiplier_pkg;

  localparam int unsigned MAX_STAGES   = 16;
  localparam int unsigned MAX_OP_WIDTH = 32;
  localparam int unsigned MAX_P_WIDTH  = 2 * MAX_OP_WIDTH;

  typedef enum logic {
    MULT_UNSIGNED = 1'b0,
    MULT_SIGNED   = 1'b1
  } mult_mode_e;

  // Operands arrive zero-extended to MAX_OP_WIDTH; a_width/b_width give their
  // real widths so the sign bit can be replicated. The low a_width+b_width bits
  // of the result are the exact product.
  function automatic logic [MAX_P_WIDTH-1:0] mul_ext(
    input logic [MAX_OP_WIDTH-1:0] a,
    input logic [MAX_OP_WIDTH-1:0] b,
    input int unsigned             a_width,
    input int unsigned             b_width,
    input mult_mode_e              mode
  );
    logic [MAX_P_WIDTH-1:0] a_ext;
    logic [MAX_P_WIDTH-1:0] b_ext;
    int unsigned            a_sh;
    int unsigned            b_sh;
    a_ext = MAX_P_WIDTH'(a);
    b_ext = MAX_P_WIDTH'(b);
    a_sh  = MAX_P_WIDTH - a_width;
    b_sh  = MAX_P_WIDTH - b_width;
    if (mode == MULT_SIGNED) begin
      a_ext = $unsigned($signed(a_ext << a_sh) >>> a_sh);
      b_ext = $unsigned($signed(b_ext << b_sh) >>> b_sh);
    end
    return a_ext * b_ext;
  endfunction

endpackage

// File: rtl/elastic_multiplier_if.sv
// Operand/product handshake bundle of the elastic multiplier.
interface elastic_multiplier_if #(
  parameter int unsigned A_WIDTH   = 16,
  parameter int unsigned B_WIDTH   = 16,
  parameter int unsigned TAG_WIDTH = 4,
  parameter int unsigned STAGES    = 4
);

  localparam int unsigned P_WIDTH   = A_WIDTH + B_WIDTH;
  localparam int unsigned OCC_WIDTH = $clog2(STAGES + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [A_WIDTH-1:0]   in_a;
  logic [B_WIDTH-1:0]   in_b;
  logic                 in_signed;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [P_WIDTH-1:0]   out_p;
  logic [TAG_WIDTH-1:0] out_tag;
  logic [OCC_WIDTH-1:0] occupancy;

  // Producer/consumer side (drives operands, accepts products).
  modport master (
    output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_p, out_tag, occupancy
  );

  // Multiplier side.
  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_p, out_tag, occupancy
  );

endinterface

// File: rtl/elastic_multiplier_pipe_stage.sv
// One elastic register slice: holds valid/data/tag, loads whenever it is
// empty or its downstream neighbour advances.
module elastic_pipe_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  up_valid,
  input  logic [DATA_WIDTH-1:0] up_data,
  input  logic [TAG_WIDTH-1:0]  up_tag,
  input  logic                  adv_in,
  output logic                  adv_out,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [TAG_WIDTH-1:0]  tag
);

  // An empty slice always accepts, which is what collapses bubbles.
  assign adv_out = !valid || adv_in;

  // Valid follows upstream on every load; payload only moves with a real beat
  // so a drained slice keeps its last value instead of toggling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
      tag   <= '0;
    end else if (adv_out) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
        tag  <= up_tag;
      end
    end
  end

endmodule

// File: rtl/elastic_multiplier.sv
// Fully pipelined multiplier with valid/ready on both sides, per-beat
// signed/unsigned mode and a tag carried alongside each product.
module elastic_multiplier
  import multiplier_pkg::*;
#(
  parameter int unsigned A_WIDTH   = 16,
  parameter int unsigned B_WIDTH   = 16,
  parameter int unsigned STAGES    = 4,
  parameter int unsigned TAG_WIDTH = 4
) (
  input logic                 clk,
  input logic                 reset_n,
  elastic_multiplier_if.slave bus
);

  localparam int unsigned P_WIDTH   = A_WIDTH + B_WIDTH;
  localparam int unsigned OCC_WIDTH = $clog2(STAGES + 1);

  if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("elastic_multiplier: STAGES=%0d outside 1..%0d", STAGES, MAX_STAGES);
  end
  if (TAG_WIDTH < 1) begin : g_bad_tag
    $error("elastic_multiplier: TAG_WIDTH must be at least 1");
  end
  if (A_WIDTH > MAX_OP_WIDTH || B_WIDTH > MAX_OP_WIDTH) begin : g_bad_width
    $error("elastic_multiplier: operand width exceeds %0d", MAX_OP_WIDTH);
  end

  logic [P_WIDTH-1:0]   in_p;
  logic [STAGES-1:0]    v;
  logic [P_WIDTH-1:0]   data [STAGES];
  logic [TAG_WIDTH-1:0] tag  [STAGES];
  logic [OCC_WIDTH-1:0] occ;

  // Mode-extended product presented to stage 0; retiming may spread it later.
  always_comb begin
    in_p = P_WIDTH'(mul_ext(MAX_OP_WIDTH'(bus.in_a), MAX_OP_WIDTH'(bus.in_b),
                            A_WIDTH, B_WIDTH, mult_mode_e'(bus.in_signed)));
  end

  // Stage chain; the advance signal ripples from the output back to the input.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                 up_valid;
    logic [P_WIDTH-1:0]   up_data;
    logic [TAG_WIDTH-1:0] up_tag;
    logic                 adv_in;
    logic                 adv_out;

    if (k == 0) begin : g_head
      assign up_valid = bus.in_valid;
      assign up_data  = in_p;
      assign up_tag   = bus.in_tag;
    end else begin : g_body
      assign up_valid = v[k-1];
      assign up_data  = data[k-1];
      assign up_tag   = tag[k-1];
    end

    if (k == STAGES - 1) begin : g_tail
      assign adv_in = bus.out_ready;
    end else begin : g_link
      assign adv_in = g_stage[k+1].adv_out;
    end

    elastic_pipe_stage #(
      .DATA_WIDTH (P_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH)
    ) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .up_valid (up_valid),
      .up_data  (up_data),
      .up_tag   (up_tag),
      .adv_in   (adv_in),
      .adv_out  (adv_out),
      .valid    (v[k]),
      .data     (data[k]),
      .tag      (tag[k])
    );
  end

  // Popcount of the held valids.
  always_comb begin
    occ = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ = occ + OCC_WIDTH'(v[k]);
    end
  end

  assign bus.in_ready  = g_stage[0].adv_out;
  assign bus.out_valid = v[STAGES-1];
  assign bus.out_p     = data[STAGES-1];
  assign bus.out_tag   = tag[STAGES-1];
  assign bus.occupancy = occ;

endmodule

// File: doc/elastic_multiplier.md
# elastic_multiplier

Parametrised, fully pipelined integer multiplier with valid/ready handshakes on both sides, per-transaction signed/unsigned mode, and a sideband tag carried alongside each product. It is the next-generation successor to the fixed-latency pipelined multiplier. Unlike that block, it tolerates downstream back-pressure without losing data and collapses bubbles. It sits between datapath producers (e.g. MAC/accumulator front-ends) and consumers that may stall.

## Interface
- `A_WIDTH`, default 16: width of operand A.
- `B_WIDTH`, default 16: width of operand B.
- `STAGES`, default 4: number of register stages; legal range 1..16.
- `TAG_WIDTH`, default 4: sideband tag width; legal range ≥1.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: the operand beat is valid.
- `in_ready` output 1: the block accepts the beat this cycle.
- `in_a` input `A_WIDTH`: operand A.
- `in_b` input `B_WIDTH`: operand B.
- `in_signed` input 1: 1 = both operands are two's complement; 0 = both are unsigned.
- `in_tag` input `TAG_WIDTH`: opaque sideband, returned with the product.
- `out_valid` output 1: the product beat is valid.
- `out_ready` input 1: the consumer accepts the beat.
- `out_p` output `A_WIDTH+B_WIDTH`: the exact product.
- `out_tag` output `TAG_WIDTH`: the tag of that product.
- `occupancy` output `$clog2(STAGES+1)`: number of valid stages currently held.

## Operation
- A transfer occurs on the input side when `in_valid && in_ready`, and on the output side when `out_valid && out_ready`.
- Product arithmetic:
  - `out_p` is the full-width exact product; there is no truncation or saturation.
  - Signed mode sign-extends both operands to `A_WIDTH+B_WIDTH` before multiplying.
  - Unsigned mode zero-extends both operands.
  - The mode is latched per beat, so mixed-mode beats may be in flight at once.
- Stage state:
  - Stage k (0..STAGES-1) holds `v[k]`, a product/partial value, and the tag.
  - Stage 0 captures `in_a*in_b` (mode-extended).
  - Later stages forward their contents unchanged. Synthesis may retime the multiply across stages; the function is unchanged.
- Advance rule, computed combinationally from the output end:
  - `adv[STAGES] = out_ready`.
  - `adv[k] = !v[k] || adv[k+1]`.
  - Stage k loads from stage k-1 (or from the input for k=0) when `adv[k]`.
  - When stage k loads, `v[k]` takes the upstream valid; otherwise the stage holds.
- Handshake outputs:
  - `in_ready = adv[0]`.
  - `out_valid = v[STAGES-1]`.
  - `out_p`/`out_tag` come from the last stage.
- Bubbles collapse: an empty stage always accepts, even while the output is stalled.
- `occupancy` is the count of set `v[k]` and is registered-state-derived (combinational popcount of `v`).
- Ordering: beats leave strictly in acceptance order. No beat is dropped or duplicated.
- Output stability: while `out_valid && !out_ready`, `out_p`/`out_tag` stay stable.
- An `in_valid` with `!in_ready` takes no effect; the producer must hold its data.

## Timing
- Reset: while `reset_n`=0, asynchronously:
  - all `v[k]`=0, all data and tag registers = 0;
  - outputs are `out_valid`=0, `out_p`=0, `out_tag`=0, `occupancy`=0;
  - `in_ready`=1 once `adv` evaluates with all stages empty.
- Reset is released synchronously in effect: the first capture happens on the first rising edge with `reset_n`=1.
- Latency: a beat accepted at edge N presents `out_valid`=1 after edge N+STAGES-1, i.e. visible in cycle N+STAGES, provided no stall.
- Throughput: 1 beat/cycle when `out_ready`=1 continuously.
- Full pipeline with `out_ready`=0: `in_ready`=0 and `occupancy`=STAGES.
- Simultaneous pop and push on a full pipeline: both succeed in the same cycle, and occupancy is unchanged.
- `STAGES`=1: the block is a single register slice, with `in_ready = !v[0] || out_ready`.
- Reset asserted mid-operation: all in-flight beats are discarded without being emitted.
- Combinational paths:
  - `out_ready` → `in_ready` is a combinational path, depth proportional to STAGES.
  - There is no `in_valid` → `out_valid` combinational path.

## Structure
- Package `multiplier_pkg`:
  - `MAX_STAGES`=16 constant;
  - function `mul_ext` performing the mode-dependent extension and product;
  - typedef `mult_mode_e` {MULT_UNSIGNED, MULT_SIGNED}.
- Sub-module `elastic_pipe_stage`:
  - parametrised data width;
  - holds valid, data and tag;
  - exposes `adv_in`/`adv_out`.
  - Instantiate it STAGES times via generate; stage 0 is fed by `mul_ext`.
- Elaboration assertions reject `STAGES` outside 1..16 and `TAG_WIDTH`<1.

## Test plan
- **Unsigned full-scale:** 16×16, STAGES=4; A=0xFFFF, B=0xFFFF, signed=0, tag=0x3 → after 4 cycles `out_p`=0xFFFE0001, tag 0x3.
- **Signed corners:**
  - A=0xFFFF, B=0xFFFF, signed=1 → `out_p`=0x00000001.
  - A=0x8000, B=0x8000 → `out_p`=0x40000000.
  - A=0x8000, B=0x0001 → `out_p`=0xFFFF8000.
- **Streaming:** 20 back-to-back beats (A=i, B=i+1, tag=i) with `out_ready`=1 → outputs in order, one per cycle, first at cycle 4, `occupancy` steady at 4.
- **Back-pressure:**
  - hold `out_ready`=0 for 10 cycles while driving beats → `in_ready` falls after exactly 4 accepts, `occupancy`=4, `out_p` held stable;
  - then release → all 4 beats drain in order with no loss.
- **Bubble collapse:** issue beats at cycles 0 and 2, hold `out_ready`=0 → both are accepted and `occupancy`=2; then `out_ready`=1 → beats emerge on consecutive cycles.
- **Reset mid-flight:** with 3 beats in flight, pulse `reset_n`=0 asynchronously between edges → immediately `out_valid`=0, `occupancy`=0, `out_p`=0; after release, no stale beats ever appear.
